// File: rtl/uart_rx_cfg_pkg.sv
// rtl/uart_rx_cfg_pkg.sv - shared UART constants, FSM state encoding and parity helper
package uart_rx_cfg_pkg;

  // Parity selection, shared with the matching transmitter
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } rx_state_t;

  // ones_odd is the XOR of the data word and the received parity bit
  function automatic logic parity_error(input int mode, input logic ones_odd);
    case (mode)
      PARITY_EVEN: return ones_odd;
      PARITY_ODD:  return ~ones_odd;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - received-word bundle between the UART receiver and its consumer
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_dv;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_busy;

  modport master (
    output o_rx_data,
    output o_rx_dv,
    output o_parity_err,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    input o_rx_data,
    input o_rx_dv,
    input o_parity_err,
    input o_frame_err,
    input o_busy
  );
endinterface

// File: rtl/uart_rx_cfg_sync2.sv
// rtl/uart_rx_cfg_sync2.sv - two-flop synchroniser for the asynchronous serial pin
module uart_rx_cfg_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic meta;

  // Resets to the idle line level so a reset never looks like a start edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= RESET_VAL;
      o_q  <= RESET_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver: mid-bit sampling, parity and framing checks
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx_serial,
  uart_rx_cfg_if.master rx_if
);
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr;
  logic                 ferr;
  logic                 start_tick;
  logic                 bit_tick;
  logic                 last_stop;

  uart_rx_cfg_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx_serial),
    .o_q     (rx_s)
  );

  // START samples half a bit in; every later sample is a full bit after the previous one
  assign start_tick = (cnt == CNT_MID);
  assign bit_tick   = (cnt == CNT_LAST);
  assign last_stop  = (state == ST_STOP) && bit_tick && (idx == STOP_LAST);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; start edges are only looked for in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rx_s) state_nxt = ST_START;
      ST_START:     if (start_tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_tick && (idx == DATA_LAST))
                      state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_tick) state_nxt = ST_STOP;
      ST_STOP:      if (last_stop) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ferr ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: if (rx_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs: strobe during the single DONE cycle, busy outside IDLE
  always_comb begin
    rx_if.o_rx_dv = (state == ST_DONE);
    rx_if.o_busy  = (state != ST_IDLE);
  end

  // Baud counter, restarted at each sample point and parked at zero when not receiving
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_START:                    cnt <= start_tick ? '0 : cnt + 1'b1;
        ST_DATA, ST_PARITY, ST_STOP: cnt <= bit_tick ? '0 : cnt + 1'b1;
        default:                     cnt <= '0;
      endcase
    end
  end

  // Sampling datapath: LSB-first shift register, bit index, running error flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      idx       <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx  <= '0;
          perr <= 1'b0;
          ferr <= 1'b0;
        end
        ST_DATA: if (bit_tick) begin
          shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
          idx       <= (idx == DATA_LAST) ? '0 : idx + 1'b1;
        end
        ST_PARITY: if (bit_tick) begin
          perr <= parity_error(PARITY_MODE, ^{shift_reg, rx_s});
        end
        ST_STOP: if (bit_tick) begin
          ferr <= ferr | ~rx_s;
          idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers load on the final stop sample so they are already valid while DONE strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_if.o_rx_data    <= '0;
      rx_if.o_parity_err <= 1'b0;
      rx_if.o_frame_err  <= 1'b0;
    end else if (last_stop) begin
      rx_if.o_rx_data    <= shift_reg;
      rx_if.o_parity_err <= perr;
      rx_if.o_frame_err  <= ferr | ~rx_s;
    end
  end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg in 8N1, 8E1 and 7O2 configurations
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] line = 3'b111;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         frame_start_cyc = 0;
  int         dv_cyc0 = 0;
  rec_t       q0[$];
  rec_t       q1[$];
  rec_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_n1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_e1 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_o2 ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(line[0]), .rx_if(if_n1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_e1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(line[1]), .rx_if(if_e1));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_o2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(line[2]), .rx_if(if_o2));

  // Strobe monitors: one record per sampled dv-high cycle
  always @(negedge clk) begin
    rec_t r;
    if (if_n1.o_rx_dv) begin
      r.data = {1'b0, if_n1.o_rx_data}; r.perr = if_n1.o_parity_err; r.ferr = if_n1.o_frame_err;
      q0.push_back(r);
      dv_cyc0 = cyc;
    end
    if (if_e1.o_rx_dv) begin
      r.data = {1'b0, if_e1.o_rx_data}; r.perr = if_e1.o_parity_err; r.ferr = if_e1.o_frame_err;
      q1.push_back(r);
    end
    if (if_o2.o_rx_dv) begin
      r.data = {2'b00, if_o2.o_rx_data}; r.perr = if_o2.o_parity_err; r.ferr = if_o2.o_frame_err;
      q2.push_back(r);
    end
  end

  // Reference model: what a correct receiver reports for a frame as sent on the line
  function automatic logic good_pbit(input logic [8:0] d, input int nbits, input int pmode);
    int ones;
    ones = $countones(d & 9'((1 << nbits) - 1));
    return (pmode == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  function automatic rec_t model(input logic [8:0] d, input int nbits, input int pmode,
                                 input logic pbit, input int nstop, input logic [1:0] stops);
    rec_t r;
    int   ones;
    r.data = d & 9'((1 << nbits) - 1);
    ones   = $countones(r.data) + int'(pbit);
    if (pmode == 1)      r.perr = (ones % 2) == 1;
    else if (pmode == 2) r.perr = (ones % 2) == 0;
    else                 r.perr = 1'b0;
    r.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    return r;
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return if_n1.o_busy;
      1:       return if_e1.o_busy;
      default: return if_o2.o_busy;
    endcase
  endfunction

  task automatic pop_rec(input int sel, output rec_t r);
    case (sel)
      0:       r = q0.pop_front();
      1:       r = q1.pop_front();
      default: r = q2.pop_front();
    endcase
  endtask

  task automatic drive_frame(input int sel, input logic [8:0] d, input int nbits, input int pmode,
                             input logic pbit, input int nstop, input logic [1:0] stops);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (pmode != 0) bits.push_back(pbit);
    for (int i = 0; i < nstop; i++) bits.push_back(stops[i]);
    for (int k = 0; k < bits.size(); k++) begin
      @(negedge clk);
      line[sel] = bits[k];
      if (k == 0) frame_start_cyc = cyc;
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic set_idle(input int sel, input int n);
    @(negedge clk);
    line[sel] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rec(input int sel, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (qsize(sel) > 0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_n1.o_rx_data, if_n1.o_rx_dv, if_n1.o_parity_err, if_n1.o_frame_err, if_n1.o_busy} !== 13'h0) begin
      errors++; $display("FAIL reset_n1: got %h expected 0",
        {if_n1.o_rx_data, if_n1.o_rx_dv, if_n1.o_parity_err, if_n1.o_frame_err, if_n1.o_busy});
    end
    checks++;
    if ({if_e1.o_rx_data, if_e1.o_rx_dv, if_e1.o_busy, if_o2.o_rx_data, if_o2.o_rx_dv, if_o2.o_busy} !== 19'h0) begin
      errors++; $display("FAIL reset_e1_o2: got %h expected 0",
        {if_e1.o_rx_data, if_e1.o_rx_dv, if_e1.o_busy, if_o2.o_rx_data, if_o2.o_rx_dv, if_o2.o_busy});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_8n1;
    rec_t exp, r;
    bit   got;
    int   lat;
    exp = model(9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    drive_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    set_idle(0, 4);
    wait_rec(0, 40, got);
    checks++;
    if (!got) begin errors++; $display("FAIL 8n1_strobe: got none expected one"); end
    else begin
      lat = dv_cyc0 - frame_start_cyc;
      pop_rec(0, r);
      checks++;
      if (r !== exp) begin errors++; $display("FAIL 8n1_word: got %h expected %h", r, exp); end
      checks++;
      if (lat < 10 * CPB - CPB / 2 || lat > 10 * CPB - CPB / 2 + 6) begin
        errors++; $display("FAIL 8n1_latency: got %0d expected about %0d", lat, 10 * CPB - CPB / 2 + 3);
      end
    end
    repeat (20) @(negedge clk);
    checks++;
    if (qsize(0) !== 0 || if_n1.o_rx_data !== 8'hA5 || if_n1.o_busy !== 1'b0) begin
      errors++; $display("FAIL 8n1_hold: got extra=%0d data=%h busy=%b expected 0 a5 0",
        qsize(0), if_n1.o_rx_data, if_n1.o_busy);
    end
  endtask

  task automatic test_parity;
    logic [8:0] words[2] = '{9'h003, 9'h007};
    rec_t exp, r;
    bit   got;
    for (int i = 0; i < 2; i++) begin
      exp = model(words[i], 8, 1, 1'b0, 1, 2'b11);
      drive_frame(1, words[i], 8, 1, 1'b0, 1, 2'b11);
      set_idle(1, 4);
      wait_rec(1, 40, got);
      checks++;
      if (!got) begin errors++; $display("FAIL parity_strobe_%0d: got none expected one", i); end
      else begin
        pop_rec(1, r);
        checks++;
        if (r !== exp) begin errors++; $display("FAIL parity_word_%0d: got %h expected %h", i, r, exp); end
      end
    end
  endtask

  task automatic test_frame_err;
    rec_t exp, r;
    bit   got;
    bit   busy_dropped;
    logic pb;
    pb  = good_pbit(9'h055, 7, 2);
    exp = model(9'h055, 7, 2, pb, 2, 2'b01);
    drive_frame(2, 9'h055, 7, 2, pb, 2, 2'b01);
    busy_dropped = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (busy_of(2) !== 1'b1) busy_dropped = 1'b1;
    end
    checks++;
    if (busy_dropped) begin errors++; $display("FAIL ferr_busy_low_line: got busy drop expected busy held"); end
    wait_rec(2, 10, got);
    checks++;
    if (!got) begin errors++; $display("FAIL ferr_strobe: got none expected one"); end
    else begin
      pop_rec(2, r);
      checks++;
      if (r !== exp) begin errors++; $display("FAIL ferr_word: got %h expected %h", r, exp); end
    end
    set_idle(2, 6);
    checks++;
    if (busy_of(2) !== 1'b0 || qsize(2) !== 0) begin
      errors++; $display("FAIL ferr_recover: got busy=%b extra=%0d expected 0 0", busy_of(2), qsize(2));
    end
  endtask

  task automatic test_break;
    rec_t r;
    bit   got;
    @(negedge clk);
    line[0] = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    checks++;
    if (qsize(0) !== 1) begin errors++; $display("FAIL break_count: got %0d expected 1", qsize(0)); end
    set_idle(0, 10);
    wait_rec(0, 5, got);
    if (got) begin
      pop_rec(0, r);
      checks++;
      if (r !== 11'b0_0000_0000_0_1) begin errors++; $display("FAIL break_word: got %h expected %h", r, 11'h001); end
    end
    checks++;
    if (qsize(0) !== 0 || busy_of(0) !== 1'b0) begin
      errors++; $display("FAIL break_retrigger: got extra=%0d busy=%b expected 0 0", qsize(0), busy_of(0));
    end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    line[0] = 1'b0;
    repeat (5) @(negedge clk);
    line[0] = 1'b1;
    repeat (CPB + 4) @(negedge clk);
    checks++;
    if (busy_of(0) !== 1'b0 || qsize(0) !== 0) begin
      errors++; $display("FAIL glitch: got busy=%b strobes=%0d expected 0 0", busy_of(0), qsize(0));
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] words[$];
    rec_t       r, exp;
    words = '{9'h000, 9'h0FF, 9'h081};
    for (int i = 0; i < 4; i++) words.push_back(9'($urandom_range(0, 255)));
    foreach (words[i]) drive_frame(0, words[i], 8, 0, 1'b0, 1, 2'b11);
    set_idle(0, 20);
    checks++;
    if (qsize(0) !== words.size()) begin
      errors++; $display("FAIL b2b_count: got %0d expected %0d", qsize(0), words.size());
    end
    foreach (words[i]) begin
      if (qsize(0) == 0) break;
      pop_rec(0, r);
      exp = model(words[i], 8, 0, 1'b0, 1, 2'b11);
      checks++;
      if (r !== exp) begin errors++; $display("FAIL b2b_word_%0d: got %h expected %h", i, r, exp); end
    end
  endtask

  task automatic test_random;
    rec_t       exp, r;
    bit         got;
    logic [8:0] d;
    logic       pb;
    logic [1:0] st;
    for (int n = 0; n < 8; n++) begin
      d  = 9'($urandom_range(0, 255));
      pb = $urandom_range(0, 1);
      exp = model(d, 8, 1, pb, 1, 2'b11);
      drive_frame(1, d, 8, 1, pb, 1, 2'b11);
      set_idle(1, $urandom_range(0, 5));
      wait_rec(1, 40, got);
      checks++;
      if (!got) begin errors++; $display("FAIL rand_e1_strobe_%0d: got none expected one", n); end
      else begin
        pop_rec(1, r);
        checks++;
        if (r !== exp) begin errors++; $display("FAIL rand_e1_word_%0d: got %h expected %h", n, r, exp); end
      end
    end
    for (int n = 0; n < 8; n++) begin
      d  = 9'($urandom_range(0, 127));
      pb = good_pbit(d, 7, 2) ^ logic'($urandom_range(0, 1));
      st = 2'($urandom_range(0, 3));
      exp = model(d, 7, 2, pb, 2, st);
      drive_frame(2, d, 7, 2, pb, 2, st);
      set_idle(2, 4);
      wait_rec(2, 40, got);
      checks++;
      if (!got) begin errors++; $display("FAIL rand_o2_strobe_%0d: got none expected one", n); end
      else begin
        pop_rec(2, r);
        checks++;
        if (r !== exp) begin errors++; $display("FAIL rand_o2_word_%0d: got %h expected %h", n, r, exp); end
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [8:0] d;
    rec_t       r;
    bit         got;
    d = 9'h03C;
    @(negedge clk);
    line[0] = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      line[0] = d[i];
      repeat (CPB) @(negedge clk);
    end
    line[0] = d[4];
    repeat (CPB / 2) @(negedge clk);
    checks++;
    if (busy_of(0) !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b expected 1", busy_of(0)); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if_n1.o_rx_data, if_n1.o_rx_dv, if_n1.o_parity_err, if_n1.o_frame_err, if_n1.o_busy} !== 13'h0) begin
      errors++; $display("FAIL midframe_reset_outputs: got %h expected 0",
        {if_n1.o_rx_data, if_n1.o_rx_dv, if_n1.o_parity_err, if_n1.o_frame_err, if_n1.o_busy});
    end
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (qsize(0) !== 0) begin errors++; $display("FAIL midframe_no_strobe: got %0d expected 0", qsize(0)); end
    drive_frame(0, 9'h012, 8, 0, 1'b0, 1, 2'b11);
    set_idle(0, 4);
    wait_rec(0, 40, got);
    checks++;
    if (!got) begin errors++; $display("FAIL after_reset_strobe: got none expected one"); end
    else begin
      pop_rec(0, r);
      checks++;
      if (r !== model(9'h012, 8, 0, 1'b0, 1, 2'b11)) begin
        errors++; $display("FAIL after_reset_word: got %h expected %h", r, model(9'h012, 8, 0, 1'b0, 1, 2'b11));
      end
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_frame_err;
    test_glitch;
    test_back_to_back;
    test_break;
    test_random;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
